store_buffer: RTL and testbench



---
 rtl/store_buffer_pkg.sv | 26 ++
 rtl/store_buffer_match.sv | 44 ++++
 rtl/store_buffer.sv | 145 ++++++++++++++
 tb/tb_store_buffer.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared types and defaults for the store buffer: the pending-entry record and
// the word-overlap test used by load/store disambiguation.
package store_buffer_pkg;

  localparam int DEPTH_DEF = 4;
  localparam int AW_DEF    = 16;
  localparam int DW_DEF    = 16;
  localparam int PTR_W     = $clog2(DEPTH_DEF);

  // Field widths follow the package defaults, so AW/DW must keep their default values.
  typedef struct packed {
    logic              valid;
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] data;
  } entry_t;

  // Two big-endian words overlap in exactly one byte when their addresses differ by one.
  function automatic logic overlaps(input logic [AW_DEF-1:0] a, input logic [AW_DEF-1:0] b);
    logic [AW_DEF-1:0] a_next;
    logic [AW_DEF-1:0] b_next;
    a_next = a + AW_DEF'(1);
    b_next = b + AW_DEF'(1);
    return (a_next == b) || (b_next == a);
  endfunction

endpackage

// File: rtl/store_buffer_match.sv
// Age-ordered compare of a load address against every pending store entry,
// walking oldest (head) to youngest so the last exact match wins.
module store_buffer_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  entry_t                     entries [DEPTH],
  input  logic   [$clog2(DEPTH)-1:0] head,
  input  logic   [AW-1:0]            ld_addr,
  output logic                       hit,
  output logic   [DW-1:0]            hit_data,
  output logic                       overlap
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  // NOTE: combinational blocks use blocking assignments and default every
  // output first, so no path leaves a value held and no latch is inferred.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    overlap  = 1'b0;
    idx      = head;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (entries[idx].valid) begin
        if (entries[idx].addr == ld_addr) begin
          // A younger exact match covers both bytes and supersedes older partial overlaps.
          hit      = 1'b1;
          hit_data = entries[idx].data;
          overlap  = 1'b0;
        end else if (overlaps(entries[idx].addr, ld_addr)) begin
          overlap = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between the datapath and the byte-addressed data memory; queues
// stores, drains one per cycle, forwards to loads. STORE_BUFFER_FLUSH_EN adds flush.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st_valid,
  input  logic [AW-1:0] st_addr,
  input  logic [DW-1:0] st_data,
  output logic          st_ready,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_ready,
  output logic [DW-1:0] ld_data,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_write,
  output logic          mem_read,
  input  logic [DW-1:0] mem_rdata,
`ifdef STORE_BUFFER_FLUSH_EN
  input  logic          flush,
  output logic          flush_done,
`endif
  output logic          empty
);

  localparam int          PW         = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  entry_t        entries [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;

  logic          hit;
  logic          overlap;
  logic [DW-1:0] hit_data;
  logic          flushing;
  logic          full;
  logic          push;
  logic          drain;
  logic          ld_fwd;
  logic          ld_mem;
  logic          ld_port;

  store_buffer_match #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_match (
    .entries  (entries),
    .head     (head),
    .ld_addr  (ld_addr),
    .hit      (hit),
    .hit_data (hit_data),
    .overlap  (overlap)
  );

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign st_ready = !full && !flushing;
  assign push     = st_valid && st_ready;

  // Overlapping loads wait for the conflicting entries to drain; misses take the port unless full.
  assign ld_fwd  = ld_valid && !flushing && hit && !overlap;
  assign ld_mem  = ld_valid && !flushing && !hit && !overlap;
  assign ld_port = ld_mem && !full;
  assign drain   = !empty && !ld_port;

  always_comb begin
    ld_ready  = 1'b0;
    ld_data   = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    // Nothing reaches memory or the load port while reset is held.
    if (!rst) begin
      if (ld_fwd) begin
        ld_ready = 1'b1;
        ld_data  = hit_data;
      end else if (ld_port) begin
        ld_ready = 1'b1;
        ld_data  = mem_rdata;
        mem_read = 1'b1;
        mem_addr = ld_addr;
      end
      if (drain) begin
        mem_write = 1'b1;
        mem_addr  = entries[head].addr;
        mem_wdata = entries[head].data;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments; only the entry valid
  // bits are reset, the address/data payload is storage and needs no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i].valid <= 1'b0;
      end
    end else begin
      if (push) begin
        entries[tail] <= '{valid: 1'b1, addr: st_addr, data: st_data};
        tail          <= tail + PW'(1);
      end
      if (drain) begin
        entries[head].valid <= 1'b0;
        head                <= head + PW'(1);
      end
      case ({push, drain})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef STORE_BUFFER_FLUSH_EN
  // Sticky until the first empty cycle, which is also the flush_done cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      flushing <= 1'b0;
    end else if (flushing && empty) begin
      flushing <= 1'b0;
    end else if (flush) begin
      flushing <= 1'b1;
    end
  end

  assign flush_done = flushing && empty && !rst;
`else
  assign flushing = 1'b0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a byte-wide memory model behind the port;
// covers drain, full arbitration, forwarding, overlap stalls, wraps, reset and flush.
module tb_store_buffer;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic        st_valid = 1'b0;
  logic [15:0] st_addr  = '0;
  logic [15:0] st_data  = '0;
  logic        st_ready;
  logic        ld_valid = 1'b0;
  logic [15:0] ld_addr  = '0;
  logic        ld_ready;
  logic [15:0] ld_data;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [15:0] mem_rdata;
  logic        empty;
`ifdef STORE_BUFFER_FLUSH_EN
  logic        flush = 1'b0;
  logic        flush_done;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [65536];
  logic        mem_init = 1'b1;
  logic [15:0] addr_next;

  store_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .st_valid   (st_valid),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .st_ready   (st_ready),
    .ld_valid   (ld_valid),
    .ld_addr    (ld_addr),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .mem_rdata  (mem_rdata),
`ifdef STORE_BUFFER_FLUSH_EN
    .flush      (flush),
    .flush_done (flush_done),
`endif
    .empty      (empty)
  );

  always #5 clk = ~clk;

  // Big-endian 16-bit memory: high byte at addr, low byte at addr+1 (wrapping).
  assign addr_next = mem_addr + 16'd1;
  assign mem_rdata = {mem[mem_addr], mem[addr_next]};

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 65536; i++) mem[i] <= 8'h00;
      mem[16'h0080] <= 8'h5E;
      mem[16'h0081] <= 8'h77;
    end else if (mem_write) begin
      mem[mem_addr]  <= mem_wdata[15:8];
      mem[addr_next] <= mem_wdata[7:0];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic wait_empty(input int max_cycles);
    int n;
    n = 0;
    while (!empty && n < max_cycles) begin
      cyc();
      n++;
    end
    settle();
    check("drain_bound", empty, 1);
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] a1;
    a1 = a + 16'd1;
    return {mem[a], mem[a1]};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset: outputs held idle even with a load request present.
    cyc();
    cyc();
    mem_init = 1'b0;
    ld_valid = 1'b1;
    ld_addr  = 16'h0080;
    settle();
    check("rst_ld_ready", ld_ready, 0);
    check("rst_mem_read", mem_read, 0);
    cyc();
    rst      = 1'b0;
    ld_valid = 1'b0;
    settle();
    check("post_rst_empty", empty, 1);
    check("post_rst_st_ready", st_ready, 1);
    check("post_rst_mem_write", mem_write, 0);
    check("post_rst_mem_read", mem_read, 0);
    check("post_rst_ld_ready", ld_ready, 0);
    check("post_rst_ld_data", ld_data, 0);
    check("post_rst_mem_addr", mem_addr, 0);
    check("post_rst_mem_wdata", mem_wdata, 0);

    // Single store drains the cycle after it is accepted.
    st_valid = 1'b1;
    st_addr  = 16'h0010;
    st_data  = 16'hA1B2;
    settle();
    check("t1_no_write_same_cycle", mem_write, 0);
    cyc();
    st_valid = 1'b0;
    settle();
    check("t1_empty_pending", empty, 0);
    check("t1_mem_write", mem_write, 1);
    check("t1_mem_addr", mem_addr, 16'h0010);
    check("t1_mem_wdata", mem_wdata, 16'hA1B2);
    cyc();
    settle();
    check("t1_empty_after", empty, 1);
    check("t1_mem_write_idle", mem_write, 0);
    check("t1_mem_word", mem_word(16'h0010), 16'hA1B2);

    // Fill to full while a missing load owns the port every cycle.
    ld_valid = 1'b1;
    ld_addr  = 16'h0080;
    for (int i = 0; i < 4; i++) begin
      st_valid = 1'b1;
      st_addr  = 16'h0040 + 16'(2 * i);
      st_data  = 16'h0101 * 16'(i + 1);
      settle();
      check("t2_fill_st_ready", st_ready, 1);
      check("t2_fill_ld_ready", ld_ready, 1);
      check("t2_fill_mem_read", mem_read, 1);
      check("t2_fill_mem_write", mem_write, 0);
      check("t2_fill_ld_data", ld_data, 16'h5E77);
      cyc();
    end
    st_addr = 16'h0048;
    st_data = 16'h0505;
    settle();
    check("t2_full_st_ready", st_ready, 0);
    check("t2_full_ld_ready", ld_ready, 0);
    check("t2_full_mem_read", mem_read, 0);
    check("t2_full_mem_write", mem_write, 1);
    check("t2_full_mem_addr", mem_addr, 16'h0040);
    check("t2_full_mem_wdata", mem_wdata, 16'h0101);
    cyc();
    st_valid = 1'b0;
    settle();
    check("t2_load_ld_ready", ld_ready, 1);
    check("t2_load_mem_read", mem_read, 1);
    check("t2_load_mem_addr", mem_addr, 16'h0080);
    check("t2_load_ld_data", ld_data, 16'h5E77);
    check("t2_load_mem_write", mem_write, 0);
    check("t2_load_st_ready", st_ready, 1);
    cyc();
    ld_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      settle();
      check("t2_drain_addr", mem_addr, 16'h0040 + 16'(2 * i));
      check("t2_drain_wdata", mem_wdata, 16'h0101 * 16'(i + 1));
      cyc();
    end
    settle();
    check("t2_empty", empty, 1);
    check("t2_rejected_store", mem_word(16'h0048), 16'h0000);

    // Forwarding: youngest match wins, same-cycle push is invisible.
    ld_valid = 1'b1;
    ld_addr  = 16'h0080;
    st_valid = 1'b1;
    st_addr  = 16'h0020;
    st_data  = 16'h1111;
    cyc();
    st_data  = 16'h2222;
    cyc();
    st_valid = 1'b0;
    ld_addr  = 16'h0020;
    settle();
    check("t3_fwd_ld_ready", ld_ready, 1);
    check("t3_fwd_ld_data", ld_data, 16'h2222);
    check("t3_fwd_mem_read", mem_read, 0);
    check("t3_fwd_drain", mem_write, 1);
    check("t3_fwd_drain_data", mem_wdata, 16'h1111);
    cyc();
    st_valid = 1'b1;
    st_data  = 16'h3333;
    settle();
    check("t3_same_cycle_push_hidden", ld_data, 16'h2222);
    cyc();
    st_valid = 1'b0;
    ld_valid = 1'b0;
    wait_empty(8);
    check("t3_mem_word", mem_word(16'h0020), 16'h3333);

    // Partial overlap stalls the load until the entry drains.
    st_valid = 1'b1;
    st_addr  = 16'h0031;
    st_data  = 16'hCAFE;
    cyc();
    st_valid = 1'b0;
    ld_valid = 1'b1;
    ld_addr  = 16'h0030;
    settle();
    check("t4_ovl_ld_ready", ld_ready, 0);
    check("t4_ovl_ld_data", ld_data, 0);
    check("t4_ovl_mem_read", mem_read, 0);
    check("t4_ovl_mem_write", mem_write, 1);
    check("t4_ovl_mem_addr", mem_addr, 16'h0031);
    cyc();
    settle();
    check("t4_after_ld_ready", ld_ready, 1);
    check("t4_after_mem_read", mem_read, 1);
    check("t4_after_ld_data", ld_data, 16'h00CA);
    cyc();
    ld_valid = 1'b0;
    st_valid = 1'b1;
    st_addr  = 16'hFFFF;
    st_data  = 16'hBEEF;
    cyc();
    st_valid = 1'b0;
    ld_valid = 1'b1;
    ld_addr  = 16'h0000;
    settle();
    check("t4_wrap_ld_ready", ld_ready, 0);
    check("t4_wrap_mem_addr", mem_addr, 16'hFFFF);
    check("t4_wrap_mem_write", mem_write, 1);
    cyc();
    settle();
    check("t4_wrap_after_ld_ready", ld_ready, 1);
    check("t4_wrap_after_ld_data", ld_data, 16'hEF00);
    cyc();
    ld_valid = 1'b0;

    // Push and drain every cycle across several pointer wraps.
    st_valid = 1'b1;
    st_addr  = 16'h0100;
    st_data  = 16'h5000;
    cyc();
    for (int i = 1; i <= 10; i++) begin
      st_addr = 16'h0100 + 16'(2 * i);
      st_data = 16'h5000 + 16'(i);
      settle();
      check("t5_mem_write", mem_write, 1);
      check("t5_order_addr", mem_addr, 16'h0100 + 16'(2 * (i - 1)));
      check("t5_order_data", mem_wdata, 16'h5000 + 16'(i - 1));
      check("t5_st_ready", st_ready, 1);
      check("t5_not_empty", empty, 0);
      cyc();
    end
    st_valid = 1'b0;
    settle();
    check("t5_last_addr", mem_addr, 16'h0114);
    check("t5_last_data", mem_wdata, 16'h500A);
    cyc();
    settle();
    check("t5_empty", empty, 1);

    // Reset with three pending entries discards them.
    ld_valid = 1'b1;
    ld_addr  = 16'h0080;
    for (int i = 0; i < 3; i++) begin
      st_valid = 1'b1;
      st_addr  = 16'h0200 + 16'(2 * i);
      st_data  = 16'hD000 + 16'(i);
      cyc();
    end
    st_valid = 1'b0;
    settle();
    check("t6_pending_mem_read", mem_read, 1);
    rst = 1'b1;
    settle();
    check("t6_rst_mem_write", mem_write, 0);
    check("t6_rst_ld_ready", ld_ready, 0);
    check("t6_rst_mem_read", mem_read, 0);
    cyc();
    rst      = 1'b0;
    ld_valid = 1'b0;
    settle();
    check("t6_empty", empty, 1);
    check("t6_mem_write", mem_write, 0);
    cyc();
    cyc();
    check("t6_word0", mem_word(16'h0200), 16'h0000);
    check("t6_word1", mem_word(16'h0202), 16'h0000);
    check("t6_word2", mem_word(16'h0204), 16'h0000);

`ifdef STORE_BUFFER_FLUSH_EN
    // Flush with three entries: three drain cycles, then one flush_done pulse.
    ld_valid = 1'b1;
    ld_addr  = 16'h0080;
    for (int i = 0; i < 3; i++) begin
      st_valid = 1'b1;
      st_addr  = 16'h0300 + 16'(2 * i);
      st_data  = 16'hF000 + 16'(i);
      cyc();
    end
    st_valid = 1'b0;
    flush    = 1'b1;
    settle();
    check("t7_flush_cycle_ld_ready", ld_ready, 1);
    check("t7_flush_cycle_mem_write", mem_write, 0);
    cyc();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("t7_drain_write", mem_write, 1);
      check("t7_drain_addr", mem_addr, 16'h0300 + 16'(2 * i));
      check("t7_drain_ld_ready", ld_ready, 0);
      check("t7_drain_st_ready", st_ready, 0);
      check("t7_drain_done", flush_done, 0);
      cyc();
    end
    settle();
    check("t7_done_pulse", flush_done, 1);
    check("t7_done_empty", empty, 1);
    cyc();
    settle();
    check("t7_done_cleared", flush_done, 0);
    check("t7_load_resumes", ld_ready, 1);
    ld_valid = 1'b0;
    flush    = 1'b1;
    settle();
    check("t7_empty_flush_same_cycle", flush_done, 0);
    cyc();
    flush = 1'b0;
    settle();
    check("t7_empty_flush_done", flush_done, 1);
    cyc();
    settle();
    check("t7_empty_flush_cleared", flush_done, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
